// File: rtl/sram_arbiter_if.sv
// Requester and SRAM pin bundle for the three-way SRAM arbiter.
// slave = arbiter side, master = requester side, mem = SRAM macro side.
interface sram_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic [2:0]      req;
  logic [2:0]      we;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]      gnt;
  logic [2:0]      ack;
  logic [DW-1:0]   rdata;
  logic [AW-1:0]   sram_addr;
  logic [DW-1:0]   sram_din;
  logic            sram_csb;
  logic            sram_web;
  logic [DW-1:0]   sram_dout;

  modport slave (
    input  req, we, addr, wdata, sram_dout,
    output gnt, ack, rdata,
    output sram_addr, sram_din, sram_csb, sram_web
  );

  modport master (
    output req, we, addr, wdata,
    input  gnt, ack, rdata
  );

  modport mem (
    input  sram_addr, sram_din, sram_csb, sram_web,
    output sram_dout
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among fetch, CU data
// and debug requesters; one 2-cycle access (ACCESS, RESP) in flight.
module sram_arbiter #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic           clock,
  input  logic           reset,
  sram_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [1:0]    rr_q, rr_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic [2:0]    own_oh;
  logic [2:0]    elig;
  logic [1:0]    pick;
  logic          grant;
  logic          in_acc, in_resp;

  assign in_acc  = (state_q == S_ACC);
  assign in_resp = (state_q == S_RESP);
  assign own_oh  = 3'b001 << owner_q;

  // The owner still holds req during RESP; keep it out of this round.
  assign elig  = bus.req & ~(in_resp ? own_oh : 3'b000);
  assign grant = !in_acc && (|elig);

  always_comb begin
    pick = 2'd0;
    unique case (rr_q)
      2'd0:    pick = elig[1] ? 2'd1 : (elig[2] ? 2'd2 : 2'd0);
      2'd1:    pick = elig[2] ? 2'd2 : (elig[0] ? 2'd0 : 2'd1);
      default: pick = elig[0] ? 2'd0 : (elig[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (1'b1)
      in_acc:  state_d = S_RESP;
      in_resp: state_d = grant ? S_ACC : S_IDLE;
      default: state_d = grant ? S_ACC : S_IDLE;
    endcase
    if (grant) begin
      owner_d = pick;
      rr_d    = pick;
      we_d    = bus.we[pick];
      addr_d  = bus.addr[int'(pick)*AW +: AW];
      wdata_d = bus.wdata[int'(pick)*DW +: DW];
    end
    if (in_resp && !we_q) rdata_d = bus.sram_dout;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      owner_q <= 2'd0;
      rr_q    <= 2'd2;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.gnt       = (in_acc || in_resp) ? own_oh : 3'b000;
  assign bus.ack       = in_resp ? own_oh : 3'b000;
  assign bus.rdata     = (in_resp && !we_q) ? bus.sram_dout : rdata_q;
  assign bus.sram_csb  = !in_acc;
  assign bus.sram_web  = in_acc ? !we_q : 1'b1;
  assign bus.sram_addr = addr_q;
  assign bus.sram_din  = wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM256x16 model.
// Cycle 0 = cycle in which the request is raised; checks at negedge.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [15:0] mem [256];

  logic [2:0]  g_exp [1:8];
  logic [2:0]  a_exp [1:8];
  logic [15:0] r_exp [1:8];

  sram_arbiter_if #(.AW(8), .DW(16)) bus ();

  sram_arbiter #(.AW(8), .DW(16)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!bus.sram_csb) begin
      if (!bus.sram_web) mem[bus.sram_addr] <= bus.sram_din;
      else               bus.sram_dout <= mem[bus.sram_addr];
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_rq(input int i, input logic w,
                        input logic [7:0] a, input logic [15:0] d);
    bus.req[i]          = 1'b1;
    bus.we[i]           = w;
    bus.addr[i*8 +: 8]  = a;
    bus.wdata[i*16 +: 16] = d;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[8'h10] = 16'hBEEF;
    mem[8'h30] = 16'hC0DE;
    bus.req = '0;
    bus.we = '0;
    bus.addr = '0;
    bus.wdata = '0;
    bus.sram_dout = '0;

    // reset state
    #2;
    check("rst_csb", 32'(bus.sram_csb), 32'd1);
    check("rst_web", 32'(bus.sram_web), 32'd1);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    check("rst_addr", 32'(bus.sram_addr), 32'd0);
    check("rst_din", 32'(bus.sram_din), 32'd0);
    step();
    rst_n = 1'b1;

    // reset during a write ACCESS
    step();
    set_rq(1, 1'b1, 8'h40, 16'h55AA);
    smp();
    step();
    smp();
    check("t1_acc_csb", 32'(bus.sram_csb), 32'd0);
    #1;
    rst_n = 1'b0;
    bus.req = '0;
    #1;
    check("t1_csb", 32'(bus.sram_csb), 32'd1);
    check("t1_web", 32'(bus.sram_web), 32'd1);
    check("t1_gnt", 32'(bus.gnt), 32'd0);
    check("t1_ack", 32'(bus.ack), 32'd0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      smp();
      check("t1_noack", 32'(bus.ack), 32'd0);
      step();
    end

    // single read
    do_reset();
    step();
    set_rq(0, 1'b0, 8'h10, 16'h0);
    smp();
    check("t2_c0_gnt", 32'(bus.gnt), 32'd0);
    step(); smp();
    check("t2_c1_gnt", 32'(bus.gnt), 32'b001);
    check("t2_c1_csb", 32'(bus.sram_csb), 32'd0);
    check("t2_c1_addr", 32'(bus.sram_addr), 32'h10);
    step(); smp();
    check("t2_c2_ack", 32'(bus.ack), 32'b001);
    check("t2_c2_rdata", 32'(bus.rdata), 32'hBEEF);
    step();
    bus.req = '0;
    smp();
    check("t2_c3_gnt", 32'(bus.gnt), 32'd0);
    check("t2_c3_csb", 32'(bus.sram_csb), 32'd1);
    check("t2_c3_rdata", 32'(bus.rdata), 32'hBEEF);

    // write then read
    step();
    set_rq(1, 1'b1, 8'h20, 16'h1234);
    smp();
    step(); smp();
    check("t3_w_gnt", 32'(bus.gnt), 32'b010);
    check("t3_w_web", 32'(bus.sram_web), 32'd0);
    check("t3_w_din", 32'(bus.sram_din), 32'h1234);
    step(); smp();
    check("t3_w_ack", 32'(bus.ack), 32'b010);
    check("t3_w_rdata", 32'(bus.rdata), 32'hBEEF);
    step();
    bus.req = '0;
    step();
    set_rq(1, 1'b0, 8'h20, 16'h0);
    smp();
    step(); smp();
    check("t3_r_gnt", 32'(bus.gnt), 32'b010);
    step(); smp();
    check("t3_r_ack", 32'(bus.ack), 32'b010);
    check("t3_r_rdata", 32'(bus.rdata), 32'h1234);
    step();
    bus.req = '0;

    // contention, all three held
    g_exp = '{3'b001, 3'b001, 3'b010, 3'b010,
              3'b100, 3'b100, 3'b001, 3'b001};
    a_exp = '{3'b000, 3'b001, 3'b000, 3'b010,
              3'b000, 3'b100, 3'b000, 3'b001};
    r_exp = '{16'h0, 16'hBEEF, 16'h0, 16'h1234,
              16'h0, 16'hC0DE, 16'h0, 16'hBEEF};
    do_reset();
    step();
    set_rq(0, 1'b0, 8'h10, 16'h0);
    set_rq(1, 1'b0, 8'h20, 16'h0);
    set_rq(2, 1'b0, 8'h30, 16'h0);
    smp();
    for (int k = 1; k <= 8; k++) begin
      step(); smp();
      check($sformatf("t4_c%0d_gnt", k), 32'(bus.gnt), 32'(g_exp[k]));
      check($sformatf("t4_c%0d_ack", k), 32'(bus.ack), 32'(a_exp[k]));
      if (a_exp[k] != 3'b000)
        check($sformatf("t4_c%0d_rdata", k), 32'(bus.rdata), 32'(r_exp[k]));
    end
    bus.req = '0;
    step(); smp();
    check("t4_idle_gnt", 32'(bus.gnt), 32'd0);

    // fairness: req0 held, req2 raised at cycle 3
    do_reset();
    step();
    set_rq(0, 1'b0, 8'h10, 16'h0);
    smp();
    step(); smp();
    check("t5_c1_gnt", 32'(bus.gnt), 32'b001);
    step(); smp();
    check("t5_c2_ack", 32'(bus.ack), 32'b001);
    step();
    set_rq(2, 1'b0, 8'h30, 16'h0);
    smp();
    step(); smp();
    check("t5_c4_gnt", 32'(bus.gnt), 32'b100);
    step(); smp();
    check("t5_c5_ack", 32'(bus.ack), 32'b100);
    check("t5_c5_rdata", 32'(bus.rdata), 32'hC0DE);
    bus.req[2] = 1'b0;
    step(); smp();
    check("t5_c6_gnt", 32'(bus.gnt), 32'b001);
    step(); smp();
    check("t5_c7_ack", 32'(bus.ack), 32'b001);
    bus.req = '0;

    // withdraw during ACCESS, then unserved pulse
    do_reset();
    step();
    set_rq(1, 1'b0, 8'h20, 16'h0);
    smp();
    step();
    bus.req[1] = 1'b0;
    smp();
    check("t6_c1_gnt", 32'(bus.gnt), 32'b010);
    step(); smp();
    check("t6_c2_ack", 32'(bus.ack), 32'b010);
    check("t6_c2_rdata", 32'(bus.rdata), 32'h1234);
    step();
    set_rq(0, 1'b0, 8'h10, 16'h0);
    set_rq(1, 1'b0, 8'h20, 16'h0);
    smp();
    step();
    bus.req[1] = 1'b0;
    smp();
    check("t6_c4_gnt", 32'(bus.gnt), 32'b001);
    step(); smp();
    check("t6_c5_ack", 32'(bus.ack), 32'b001);
    bus.req = '0;
    step(); smp();
    check("t6_c6_gnt", 32'(bus.gnt), 32'd0);
    step(); smp();
    check("t6_c7_gnt", 32'(bus.gnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
